// File: rtl/multicore_memory_arbiter.sv
// Shared-RAM arbiter for CPUS cores: data requests outrank instruction requests,
// round-robin within each class, registered grant held until ACCESS/ERROR/timeout.
module multicore_memory_arbiter #(
    parameter int CPUS    = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64,
    localparam int OW     = (CPUS > 1) ? $clog2(CPUS) : 1,
    localparam int CW     = $clog2(TIMEOUT)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [CPUS-1:0]      iREN,
    input  logic [CPUS*AW-1:0]   iaddr,
    input  logic [CPUS-1:0]      dREN,
    input  logic [CPUS-1:0]      dWEN,
    input  logic [CPUS*AW-1:0]   daddr,
    input  logic [CPUS*DW-1:0]   dstore,
    output logic [CPUS-1:0]      iwait,
    output logic [CPUS-1:0]      dwait,
    output logic [CPUS*DW-1:0]   iload,
    output logic [CPUS*DW-1:0]   dload,
    output logic [CPUS-1:0]      merr,
    output logic                 ramREN,
    output logic                 ramWEN,
    output logic [AW-1:0]        ramaddr,
    output logic [DW-1:0]        ramstore,
    input  logic [DW-1:0]        ramload,
    input  logic [1:0]           ramstate,
    output logic                 dbg_state,
    output logic [OW-1:0]        dbg_owner,
    output logic                 dbg_data,
    output logic                 dbg_write,
    output logic [OW-1:0]        dbg_dptr,
    output logic [OW-1:0]        dbg_iptr
);

    typedef enum logic {IDLE = 1'b0, SERVE = 1'b1} state_t;

    state_t          state;
    logic [OW-1:0]   owner, dptr, iptr, d_pick, i_pick, scan;
    logic            own_data, own_wr;
    logic [CW-1:0]   cnt;
    logic [CPUS-1:0] d_act;
    logic            d_any, i_any;
    logic            live, serving, done_ok, done_err, done;
    logic [AW-1:0]   o_daddr, o_iaddr;
    logic [DW-1:0]   o_store;

    function automatic logic [OW-1:0] wrap_inc(input logic [OW-1:0] v);
        return (int'(v) == CPUS - 1) ? '0 : v + 1'b1;
    endfunction

    assign d_act = dREN | dWEN;

    // Scan from the far end back toward the pointer so the nearest active core wins.
    always_comb begin
        d_any  = 1'b0;
        i_any  = 1'b0;
        d_pick = dptr;
        i_pick = iptr;
        scan   = '0;
        for (int k = CPUS - 1; k >= 0; k--) begin
            scan = OW'((int'(dptr) + k) % CPUS);
            if (d_act[scan]) begin
                d_any  = 1'b1;
                d_pick = scan;
            end
            scan = OW'((int'(iptr) + k) % CPUS);
            if (iREN[scan]) begin
                i_any  = 1'b1;
                i_pick = scan;
            end
        end
    end

    assign o_daddr  = daddr[owner*AW +: AW];
    assign o_iaddr  = iaddr[owner*AW +: AW];
    assign o_store  = dstore[owner*DW +: DW];
    assign live     = own_data ? d_act[owner] : iREN[owner];
    assign serving  = (state == SERVE) && live;
    assign done_ok  = serving && (ramstate == 2'd2);
    assign done_err = serving && !done_ok && ((ramstate == 2'd3) || (cnt == CW'(TIMEOUT - 1)));
    // A reset cycle never reports a completion to the cores.
    assign done     = (done_ok || done_err) && !RST;

    always_comb begin
        iwait    = '1;
        dwait    = '1;
        merr     = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        if (serving) begin
            if (own_data) begin
                ramWEN  = dWEN[owner];
                ramREN  = !dWEN[owner];
                ramaddr = o_daddr;
                if (dWEN[owner]) ramstore = o_store;
            end else begin
                ramREN  = 1'b1;
                ramaddr = o_iaddr;
            end
        end
        if (done) begin
            if (own_data) dwait[owner] = 1'b0;
            else          iwait[owner] = 1'b0;
            merr[owner] = done_err;
        end
    end

    assign iload = {CPUS{ramload}};
    assign dload = {CPUS{ramload}};

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            owner    <= '0;
            own_data <= 1'b0;
            own_wr   <= 1'b0;
            dptr     <= '0;
            iptr     <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (d_any) begin
                        owner    <= d_pick;
                        own_data <= 1'b1;
                        own_wr   <= dWEN[d_pick];
                        state    <= SERVE;
                    end else if (i_any) begin
                        owner    <= i_pick;
                        own_data <= 1'b0;
                        own_wr   <= 1'b0;
                        state    <= SERVE;
                    end
                end
                SERVE: begin
                    if (!live) begin
                        state <= IDLE;
                    end else if (done) begin
                        state <= IDLE;
                        if (own_data) dptr <= wrap_inc(owner);
                        else          iptr <= wrap_inc(owner);
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dbg_state = (state == SERVE);
    assign dbg_owner = owner;
    assign dbg_data  = own_data;
    assign dbg_write = own_wr;
    assign dbg_dptr  = dptr;
    assign dbg_iptr  = iptr;

endmodule

// File: tb/tb_multicore_memory_arbiter.sv
// Bench for multicore_memory_arbiter (CPUS=2, TIMEOUT=4): directed table, round-robin
// sequence, then random traffic against a cycle-level reference model.
module tb_multicore_memory_arbiter;

    localparam int CPUS = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TIMEOUT = 4;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic RST;
    logic [CPUS-1:0] iREN, dREN, dWEN, iwait, dwait, merr;
    logic [CPUS*AW-1:0] iaddr, daddr;
    logic [CPUS*DW-1:0] dstore, iload, dload;
    logic ramREN, ramWEN;
    logic [AW-1:0] ramaddr;
    logic [DW-1:0] ramstore, ramload;
    logic [1:0] ramstate;
    logic dbg_state, dbg_data, dbg_write;
    logic [0:0] dbg_owner, dbg_dptr, dbg_iptr;

    multicore_memory_arbiter #(.CPUS(CPUS), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
        .daddr(daddr), .dstore(dstore), .iwait(iwait), .dwait(dwait), .iload(iload),
        .dload(dload), .merr(merr), .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
        .dbg_state(dbg_state), .dbg_owner(dbg_owner), .dbg_data(dbg_data),
        .dbg_write(dbg_write), .dbg_dptr(dbg_dptr), .dbg_iptr(dbg_iptr)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  ir, dr, dw, rs;
        logic [31:0] da1;
        logic        e_ren, e_wen;
        logic [1:0]  e_iw, e_dw, e_me;
        logic [31:0] e_addr, e_store;
    } vec_t;

    vec_t tab[$];
    int n_vec = 0;
    int n_err = 0;

    // reference model state
    bit m_busy, m_data, m_live, m_ok, m_bad, m_found;
    int m_core, m_cnt, m_dptr, m_iptr, pc;
    logic e_ren, e_wen;
    logic [1:0] e_iw, e_dw, e_me;
    logic [31:0] e_addr, e_store;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    task automatic row(input logic rst, input logic [1:0] ir, dr, dw, rs, input logic [31:0] da1,
                       input logic ren, wen, input logic [1:0] iw, dwe, me,
                       input logic [31:0] addr, store);
        vec_t v;
        v.rst = rst; v.ir = ir; v.dr = dr; v.dw = dw; v.rs = rs; v.da1 = da1;
        v.e_ren = ren; v.e_wen = wen; v.e_iw = iw; v.e_dw = dwe; v.e_me = me;
        v.e_addr = addr; v.e_store = store;
        tab.push_back(v);
    endtask

    task automatic do_reset();
        RST = 1'b1; iREN = '0; dREN = '0; dWEN = '0; ramstate = 2'd0;
        @(posedge CLK); @(posedge CLK); @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic chk_outputs(input string tag, input logic ren, wen, input logic [1:0] iw, dwe, me,
                               input logic [31:0] addr, store);
        chk({tag, "_ctl"}, {ramREN, ramWEN, iwait, dwait, merr}, {ren, wen, iw, dwe, me});
        chk({tag, "_addr"}, ramaddr, addr);
        chk({tag, "_store"}, ramstore, store);
    endtask

    initial begin
        iaddr = {32'h1004, 32'h1000};
        daddr = {32'h40, 32'h80};
        dstore = {32'hDEADBEEF, 32'h11111111};
        ramload = 32'hCAFE0001;
        do_reset();

        // rst ir dr dw rs da1 | ren wen iw dw me addr store
        row(1, 2'b11, 2'b11, 2'b00, 0, 32'h40,  0, 0, 2'b11, 2'b11, 2'b00, 0, 0);
        row(1, 2'b11, 2'b11, 2'b00, 0, 32'h40,  0, 0, 2'b11, 2'b11, 2'b00, 0, 0);
        row(0, 2'b11, 2'b11, 2'b00, 0, 32'h40,  0, 0, 2'b11, 2'b11, 2'b00, 0, 0);
        row(0, 2'b11, 2'b11, 2'b00, 2, 32'h40,  1, 0, 2'b11, 2'b10, 2'b00, 32'h80, 0);
        row(0, 2'b00, 2'b00, 2'b00, 0, 32'h40,  0, 0, 2'b11, 2'b11, 2'b00, 0, 0);
        // data over instruction
        row(0, 2'b01, 2'b10, 2'b00, 0, 32'h40,  0, 0, 2'b11, 2'b11, 2'b00, 0, 0);
        row(0, 2'b01, 2'b10, 2'b00, 2, 32'h40,  1, 0, 2'b11, 2'b01, 2'b00, 32'h40, 0);
        row(0, 2'b01, 2'b00, 2'b00, 0, 32'h40,  0, 0, 2'b11, 2'b11, 2'b00, 0, 0);
        row(0, 2'b01, 2'b00, 2'b00, 2, 32'h40,  1, 0, 2'b10, 2'b11, 2'b00, 32'h1000, 0);
        row(0, 2'b00, 2'b00, 2'b00, 0, 32'h100, 0, 0, 2'b11, 2'b11, 2'b00, 0, 0);
        // write
        row(0, 2'b00, 2'b00, 2'b10, 0, 32'h100, 0, 0, 2'b11, 2'b11, 2'b00, 0, 0);
        row(0, 2'b00, 2'b00, 2'b10, 1, 32'h100, 0, 1, 2'b11, 2'b11, 2'b00, 32'h100, 32'hDEADBEEF);
        row(0, 2'b00, 2'b00, 2'b10, 1, 32'h100, 0, 1, 2'b11, 2'b11, 2'b00, 32'h100, 32'hDEADBEEF);
        row(0, 2'b00, 2'b00, 2'b10, 2, 32'h100, 0, 1, 2'b11, 2'b01, 2'b00, 32'h100, 32'hDEADBEEF);
        row(0, 2'b00, 2'b00, 2'b00, 0, 32'h40,  0, 0, 2'b11, 2'b11, 2'b00, 0, 0);
        // timeout after 4 SERVE cycles
        row(0, 2'b10, 2'b00, 2'b00, 1, 32'h40,  0, 0, 2'b11, 2'b11, 2'b00, 0, 0);
        row(0, 2'b10, 2'b00, 2'b00, 1, 32'h40,  1, 0, 2'b11, 2'b11, 2'b00, 32'h1004, 0);
        row(0, 2'b10, 2'b00, 2'b00, 1, 32'h40,  1, 0, 2'b11, 2'b11, 2'b00, 32'h1004, 0);
        row(0, 2'b10, 2'b00, 2'b00, 1, 32'h40,  1, 0, 2'b11, 2'b11, 2'b00, 32'h1004, 0);
        row(0, 2'b10, 2'b00, 2'b00, 1, 32'h40,  1, 0, 2'b01, 2'b11, 2'b10, 32'h1004, 0);
        row(0, 2'b00, 2'b00, 2'b00, 0, 32'h40,  0, 0, 2'b11, 2'b11, 2'b00, 0, 0);
        // error on first SERVE cycle
        row(0, 2'b10, 2'b00, 2'b00, 3, 32'h40,  0, 0, 2'b11, 2'b11, 2'b00, 0, 0);
        row(0, 2'b10, 2'b00, 2'b00, 3, 32'h40,  1, 0, 2'b01, 2'b11, 2'b10, 32'h1004, 0);
        row(0, 2'b00, 2'b00, 2'b00, 0, 32'h40,  0, 0, 2'b11, 2'b11, 2'b00, 0, 0);
        // abort keeps dptr
        row(0, 2'b00, 2'b01, 2'b00, 0, 32'h40,  0, 0, 2'b11, 2'b11, 2'b00, 0, 0);
        row(0, 2'b00, 2'b01, 2'b00, 1, 32'h40,  1, 0, 2'b11, 2'b11, 2'b00, 32'h80, 0);
        row(0, 2'b00, 2'b00, 2'b00, 2, 32'h40,  0, 0, 2'b11, 2'b11, 2'b00, 0, 0);
        row(0, 2'b00, 2'b11, 2'b00, 0, 32'h40,  0, 0, 2'b11, 2'b11, 2'b00, 0, 0);
        row(0, 2'b00, 2'b11, 2'b00, 2, 32'h40,  1, 0, 2'b11, 2'b10, 2'b00, 32'h80, 0);
        // reset mid-SERVE restores pointers
        row(0, 2'b00, 2'b10, 2'b00, 0, 32'h40,  0, 0, 2'b11, 2'b11, 2'b00, 0, 0);
        row(1, 2'b00, 2'b10, 2'b00, 1, 32'h40,  1, 0, 2'b11, 2'b11, 2'b00, 32'h40, 0);
        row(0, 2'b00, 2'b00, 2'b00, 0, 32'h40,  0, 0, 2'b11, 2'b11, 2'b00, 0, 0);
        row(0, 2'b00, 2'b11, 2'b00, 0, 32'h40,  0, 0, 2'b11, 2'b11, 2'b00, 0, 0);
        row(0, 2'b00, 2'b11, 2'b00, 2, 32'h40,  1, 0, 2'b11, 2'b10, 2'b00, 32'h80, 0);
        row(0, 2'b00, 2'b00, 2'b00, 0, 32'h40,  0, 0, 2'b11, 2'b11, 2'b00, 0, 0);

        foreach (tab[i]) begin
            RST = tab[i].rst; iREN = tab[i].ir; dREN = tab[i].dr; dWEN = tab[i].dw;
            ramstate = tab[i].rs; daddr[63:32] = tab[i].da1;
            #1;
            chk_outputs($sformatf("row%0d", i), tab[i].e_ren, tab[i].e_wen, tab[i].e_iw,
                        tab[i].e_dw, tab[i].e_me, tab[i].e_addr, tab[i].e_store);
            @(posedge CLK); @(negedge CLK);
        end

        // round-robin: both cores write continuously, RAM always ACCESS
        do_reset();
        daddr[63:32] = 32'h40;
        dWEN = 2'b11; dREN = 2'b00; ramstate = 2'd2;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (k % 2 == 0) begin
                chk_outputs($sformatf("rr%0d", k), 0, 0, 2'b11, 2'b11, 2'b00, 0, 0);
            end else begin
                int o;
                o = (k / 2) % 2;
                chk_outputs($sformatf("rr%0d", k), 0, 1, 2'b11, 2'b11 & ~(2'b01 << o), 2'b00,
                            (o == 0) ? 32'h80 : 32'h40,
                            (o == 0) ? 32'h11111111 : 32'hDEADBEEF);
            end
            @(posedge CLK); @(negedge CLK);
        end

        // random traffic against the reference model
        do_reset();
        m_busy = 0; m_data = 0; m_core = 0; m_cnt = 0; m_dptr = 0; m_iptr = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            int r;
            RST = ($urandom_range(0, 63) == 0);
            for (int c = 0; c < CPUS; c++) begin
                if ($urandom_range(0, 3) == 0) begin
                    iREN[c] = 1'($urandom_range(0, 1));
                    dREN[c] = 1'($urandom_range(0, 1));
                    dWEN[c] = ($urandom_range(0, 2) == 0);
                end
            end
            r = $urandom_range(0, 9);
            ramstate = (r < 5) ? 2'd1 : (r < 8) ? 2'd2 : (r == 8) ? 2'd3 : 2'd0;
            iaddr = {$urandom, $urandom};
            daddr = {$urandom, $urandom};
            dstore = {$urandom, $urandom};
            ramload = $urandom;

            e_ren = 0; e_wen = 0; e_iw = 2'b11; e_dw = 2'b11; e_me = 2'b00;
            e_addr = 0; e_store = 0; m_live = 0; m_ok = 0; m_bad = 0;
            if (m_busy) begin
                m_live = m_data ? (dREN[m_core] | dWEN[m_core]) : iREN[m_core];
                if (m_live) begin
                    if (m_data) begin
                        e_wen = dWEN[m_core];
                        e_ren = !dWEN[m_core];
                        e_addr = daddr[m_core*AW +: AW];
                        if (dWEN[m_core]) e_store = dstore[m_core*DW +: DW];
                    end else begin
                        e_ren = 1;
                        e_addr = iaddr[m_core*AW +: AW];
                    end
                    m_ok = (ramstate == 2'd2);
                    m_bad = !m_ok && (ramstate == 2'd3 || m_cnt == TIMEOUT - 1);
                    if (!RST && (m_ok || m_bad)) begin
                        if (m_data) e_dw[m_core] = 1'b0;
                        else        e_iw[m_core] = 1'b0;
                        e_me[m_core] = m_bad;
                    end
                end
            end
            #1;
            chk_outputs($sformatf("rnd%0d", cyc), e_ren, e_wen, e_iw, e_dw, e_me, e_addr, e_store);
            chk($sformatf("rnd%0d_load", cyc), {iload, dload}, {4{ramload}});
            @(posedge CLK);
            if (RST) begin
                m_busy = 0; m_core = 0; m_data = 0; m_cnt = 0; m_dptr = 0; m_iptr = 0;
            end else if (!m_busy) begin
                m_found = 0;
                for (int k = 0; k < CPUS; k++) begin
                    pc = (m_dptr + k) % CPUS;
                    if (!m_found && (dREN[pc] | dWEN[pc])) begin
                        m_found = 1; m_core = pc; m_data = 1;
                    end
                end
                for (int k = 0; k < CPUS; k++) begin
                    pc = (m_iptr + k) % CPUS;
                    if (!m_found && iREN[pc]) begin
                        m_found = 1; m_core = pc; m_data = 0;
                    end
                end
                m_busy = m_found;
                m_cnt = 0;
            end else if (!m_live) begin
                m_busy = 0;
            end else if (m_ok || m_bad) begin
                m_busy = 0;
                if (m_data) m_dptr = (m_core + 1) % CPUS;
                else        m_iptr = (m_core + 1) % CPUS;
            end else begin
                m_cnt++;
            end
            @(negedge CLK);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
